// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronised line, mid-bit sampling,
// optional parity, 1 or 2 stop bits, one-word holding register with valid/ready.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 521,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 rx_clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                CNT_W         = $clog2(CLKS_PER_BIT);
    localparam int                HALF          = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0]  CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [3:0]        DATA_LAST     = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST     = 4'(STOP_BITS - 1);
    localparam logic              PAR_ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_flag_q, par_flag_d;
    logic                   frm_flag_q, frm_flag_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;
    logic                   tick;
    logic                   complete;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == CNT_BIT_LAST);

    // NOTE: every flop is updated with <= so all registers see pre-edge values;
    // blocking assignments here would make results depend on statement order.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            frm_flag_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], rx_in};
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            frm_flag_q   <= frm_flag_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // NOTE: each variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        complete   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d    = S_START;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_cnt_q == 4'(i)) shift_d[i] = rx_s;
                    end
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d      = '0;
                    par_flag_d = ((^shift_q) ^ rx_s) != PAR_ODD;
                    state_d    = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d      = '0;
                    frm_flag_d = frm_flag_q | ~rx_s;
                    if (bit_cnt_q == STOP_LAST) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        // A low final stop means the line may be in break; wait it out.
                        state_d   = rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (complete && (!rx_valid_q || rx_ready)) begin
            rx_data_d    = shift_q;
            parity_err_d = par_flag_q;
            frame_err_d  = frm_flag_d;
            rx_valid_d   = 1'b1;
        end else if (complete) begin
            overrun_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 9O2) at 16 clocks/bit,
// frame-level expectation model plus a per-cycle output monitor.
module tb_uart_rx_param;

    localparam int CPB = 16;

    typedef struct {
        int         idx;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       rx_clk;
    logic       rst;
    logic       rx_line [3];
    logic       rdy     [3];
    logic       vld     [3];
    logic       perr    [3];
    logic       ferr    [3];
    logic       ovr     [3];
    logic       bsy     [3];
    logic [7:0] d0, d1;
    logic [8:0] d2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    int         rise_cnt [3];
    int         ovr_cnt  [3];
    int         rise_cyc [3];
    int         cur_len  [3];
    int         last_len [3];
    logic [8:0] last_data[3];
    logic       last_perr[3];
    logic       last_ferr[3];
    logic       prev_v   [3];
    logic       prev_c   [3];
    logic       prev_o   [3];
    logic [8:0] prev_d   [3];
    logic       prev_pe  [3];
    logic       prev_fe  [3];

    uart_rx_param #(.CLKS_PER_BIT(CPB)) u_dut0 (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[0]), .rx_data(d0),
        .rx_valid(vld[0]), .rx_ready(rdy[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0])
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[1]), .rx_data(d1),
        .rx_valid(vld[1]), .rx_ready(rdy[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1])
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .rx_clk(rx_clk), .rst(rst), .rx_in(rx_line[2]), .rx_data(d2),
        .rx_valid(vld[2]), .rx_ready(rdy[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2])
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] dut_data(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return d2;
        endcase
    endfunction

    // Frame-level model: error flags follow directly from the bits put on the wire.
    function automatic exp_t model_frame(input int idx, input logic [8:0] data, input int nbits,
                                         input int par_mode, input logic par_bit,
                                         input logic stop0, input logic stop1, input int nstop);
        exp_t       e;
        logic [8:0] mask;
        logic       x;
        mask   = (nbits == 9) ? 9'h1FF : 9'h0FF;
        x      = (^(data & mask)) ^ par_bit;
        e.idx  = idx;
        e.data = data & mask;
        e.perr = (par_mode == 1) ? (x != 1'b1) : (par_mode == 2) ? (x != 1'b0) : 1'b0;
        e.ferr = !stop0 || ((nstop == 2) && !stop1);
        return e;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input int nbits,
                              input int par_mode, input logic par_bit,
                              input logic stop0, input logic stop1, input int nstop,
                              input bit push, output int start_cyc);
        if (push) exp_q.push_back(model_frame(idx, data, nbits, par_mode, par_bit, stop0, stop1, nstop));
        start_cyc    = cyc;
        rx_line[idx] = 1'b0;
        wait_clks(CPB);
        for (int b = 0; b < nbits; b++) begin
            rx_line[idx] = data[b];
            wait_clks(CPB);
        end
        if (par_mode != 0) begin
            rx_line[idx] = par_bit;
            wait_clks(CPB);
        end
        rx_line[idx] = stop0;
        wait_clks(CPB);
        if (nstop == 2) begin
            rx_line[idx] = stop1;
            wait_clks(CPB);
        end
    endtask

    // Per-cycle monitor: consumed words against the model, held-word stability, overrun width.
    always @(negedge rx_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                prev_v[i]  = 1'b0;
                prev_c[i]  = 1'b0;
                prev_o[i]  = 1'b0;
                cur_len[i] = 0;
            end else begin
                if (vld[i] && !prev_v[i]) begin
                    rise_cnt[i]++;
                    rise_cyc[i] = cyc;
                    cur_len[i]  = 0;
                end
                if (vld[i]) cur_len[i]++;
                else if (prev_v[i]) last_len[i] = cur_len[i];
                if (vld[i] && prev_v[i] && !prev_c[i]) begin
                    check($sformatf("hold_data_dut%0d", i), 32'(dut_data(i)), 32'(prev_d[i]));
                    check($sformatf("hold_perr_dut%0d", i), 32'(perr[i]), 32'(prev_pe[i]));
                    check($sformatf("hold_ferr_dut%0d", i), 32'(ferr[i]), 32'(prev_fe[i]));
                end
                if (ovr[i]) begin
                    ovr_cnt[i]++;
                    check($sformatf("overrun_width_dut%0d", i), 32'(prev_o[i]), 32'd0);
                end
                if (vld[i] && rdy[i]) begin
                    check($sformatf("word_expected_dut%0d", i), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("word_port_dut%0d", i), 32'(e.idx), 32'(i));
                        check($sformatf("word_data_dut%0d", i), 32'(dut_data(i)), 32'(e.data));
                        check($sformatf("word_perr_dut%0d", i), 32'(perr[i]), 32'(e.perr));
                        check($sformatf("word_ferr_dut%0d", i), 32'(ferr[i]), 32'(e.ferr));
                    end
                    last_data[i] = dut_data(i);
                    last_perr[i] = perr[i];
                    last_ferr[i] = ferr[i];
                end
                prev_v[i]  = vld[i];
                prev_c[i]  = vld[i] && rdy[i];
                prev_o[i]  = ovr[i];
                prev_d[i]  = dut_data(i);
                prev_pe[i] = perr[i];
                prev_fe[i] = ferr[i];
            end
        end
    end

    initial begin
        int t0, rb, ob, lat;
        for (int i = 0; i < 3; i++) begin
            rx_line[i]  = 1'b1;
            rdy[i]      = 1'b1;
            rise_cnt[i] = 0;
            ovr_cnt[i]  = 0;
            last_len[i] = 0;
            last_data[i] = '0;
            last_perr[i] = 1'b0;
            last_ferr[i] = 1'b0;
        end
        rst = 1'b1;
        wait_clks(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_data_dut%0d", i), 32'(dut_data(i)), 32'd0);
            check($sformatf("reset_valid_dut%0d", i), 32'(vld[i]), 32'd0);
            check($sformatf("reset_flags_dut%0d", i), 32'({perr[i], ferr[i], ovr[i]}), 32'd0);
            check($sformatf("reset_busy_dut%0d", i), 32'(bsy[i]), 32'd0);
        end
        rst = 1'b0;
        wait_clks(5);

        // 8N1 word with consumer ready: latency near 9.5 bit times, one-cycle valid.
        rb = rise_cnt[0];
        send_frame(0, 9'h0E3, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1, t0);
        wait_clks(20);
        lat = rise_cyc[0] - t0;
        check("s1_one_word", 32'(rise_cnt[0] - rb), 32'd1);
        check("s1_latency_in_window", 32'(lat >= 149 && lat <= 155), 32'd1);
        check("s1_valid_one_cycle", 32'(last_len[0]), 32'd1);
        check("s1_data", 32'(last_data[0]), 32'h0E3);
        check("s1_no_errors", 32'({last_perr[0], last_ferr[0]}), 32'd0);

        // Even parity: wrong parity bit then correct parity bit.
        send_frame(1, 9'h05A, 8, 2, 1'b1, 1'b1, 1'b1, 1, 1'b1, t0);
        wait_clks(20);
        check("s2_bad_par_data", 32'(last_data[1]), 32'h05A);
        check("s2_bad_par_flag", 32'(last_perr[1]), 32'd1);
        send_frame(1, 9'h05A, 8, 2, 1'b0, 1'b1, 1'b1, 1, 1'b1, t0);
        wait_clks(20);
        check("s2_good_par_flag", 32'(last_perr[1]), 32'd0);
        check("s2_good_par_ferr", 32'(last_ferr[1]), 32'd0);

        // Stop bit 0 followed by a 3-bit-time break.
        rb = rise_cnt[0];
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0, 1'b1, 1, 1'b1, t0);
        wait_clks(24);
        check("s3_busy_in_break", 32'(bsy[0]), 32'd1);
        wait_clks(24);
        rx_line[0] = 1'b1;
        wait_clks(6);
        check("s3_busy_released", 32'(bsy[0]), 32'd0);
        wait_clks(200);
        check("s3_single_word", 32'(rise_cnt[0] - rb), 32'd1);
        check("s3_data", 32'(last_data[0]), 32'h03C);
        check("s3_frame_err", 32'(last_ferr[0]), 32'd1);
        check("s3_parity_clear", 32'(last_perr[0]), 32'd0);

        // Overrun: consumer stalled across two frames, second word dropped.
        rdy[0] = 1'b0;
        ob = ovr_cnt[0];
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1, t0);
        wait_clks(16);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0, t0);
        wait_clks(20);
        check("s4_overrun_once", 32'(ovr_cnt[0] - ob), 32'd1);
        check("s4_held_data", 32'(d0), 32'h11);
        check("s4_still_valid", 32'(vld[0]), 32'd1);
        rdy[0] = 1'b1;
        wait_clks(3);
        check("s4_valid_fell", 32'(vld[0]), 32'd0);
        check("s4_consumed_data", 32'(last_data[0]), 32'h011);

        // Short low glitch on an idle line.
        rb = rise_cnt[0];
        rx_line[0] = 1'b0;
        wait_clks(4);
        check("s5_busy_on_glitch", 32'(bsy[0]), 32'd1);
        rx_line[0] = 1'b1;
        wait_clks(30);
        check("s5_busy_idle", 32'(bsy[0]), 32'd0);
        check("s5_no_word", 32'(rise_cnt[0] - rb), 32'd0);

        // Reset in the middle of data bit 3 of 0xA5, then a clean frame.
        rb = rise_cnt[0];
        ob = ovr_cnt[0];
        rx_line[0] = 1'b0;
        wait_clks(CPB);
        for (int b = 0; b < 3; b++) begin
            rx_line[0] = b[0] ? 1'b0 : 1'b1;
            wait_clks(CPB);
        end
        rx_line[0] = 1'b0;
        wait_clks(8);
        rst = 1'b1;
        #1;
        check("s6_rst_data", 32'(d0), 32'd0);
        check("s6_rst_valid", 32'(vld[0]), 32'd0);
        check("s6_rst_flags", 32'({perr[0], ferr[0], ovr[0]}), 32'd0);
        check("s6_rst_busy", 32'(bsy[0]), 32'd0);
        rx_line[0] = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(20);
        check("s6_no_delivery", 32'(rise_cnt[0] - rb), 32'd0);
        check("s6_no_overrun", 32'(ovr_cnt[0] - ob), 32'd0);
        send_frame(0, 9'h096, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1, t0);
        wait_clks(20);
        check("s6_after_rst_word", 32'(rise_cnt[0] - rb), 32'd1);
        check("s6_data", 32'(last_data[0]), 32'h096);
        check("s6_no_errors", 32'({last_perr[0], last_ferr[0]}), 32'd0);

        // 9 data bits, odd parity (0x1A5 has five ones so the parity bit is 0), two stops.
        rb = rise_cnt[2];
        send_frame(2, 9'h1A5, 9, 1, 1'b0, 1'b1, 1'b1, 2, 1'b1, t0);
        wait_clks(20);
        check("s7_one_word", 32'(rise_cnt[2] - rb), 32'd1);
        check("s7_data", 32'(last_data[2]), 32'h1A5);
        check("s7_no_errors", 32'({last_perr[2], last_ferr[2]}), 32'd0);

        check("all_words_delivered", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLKS_PER_BIT, 521: rx_clk cycles per bit; legal range >= 8.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- rx_clk, in, 1: clock, all state on rising edge.
- rst, in, 1: asynchronous active-high reset.
- rx_in, in, 1: serial line, idle high, LSB first.
- rx_data, out, DATA_BITS: received word.
- rx_valid, out, 1: rx_data holds an unconsumed word.
- rx_ready, in, 1: consumer accepts the word.
- parity_err, out, 1: parity mismatch for the held word.
- frame_err, out, 1: a stop bit sampled 0 for the held word.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.
- busy, out, 1: FSM not in IDLE.

Function
REQ-004 rx_in SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value only.
REQ-005 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-006 IDLE SHALL go to START when synced rx_in = 0, and clear the bit counter.
REQ-007 START SHALL count H = (CLKS_PER_BIT-1)/2 cycles, then sample. If the sample is 1 (glitch), it SHALL return to IDLE; if 0, it SHALL go to DATA.
REQ-008 DATA SHALL sample every CLKS_PER_BIT cycles and shift the sample into bit index 0..DATA_BITS-1 (LSB first). After the last bit it SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-009 PARITY SHALL sample one bit after CLKS_PER_BIT cycles.
- Odd: XOR of data bits and parity bit must be 1.
- Even: that XOR must be 0.
- A mismatch SHALL set an internal parity flag.
REQ-010 STOP SHALL sample STOP_BITS bits at CLKS_PER_BIT spacing; any 0 SHALL set an internal frame flag.
REQ-011 On the last stop sample the word SHALL complete. The FSM SHALL go to IDLE if that sample is 1, else to WAIT_IDLE.
REQ-012 WAIT_IDLE SHALL hold until synced rx_in = 1, then go to IDLE. It SHALL NOT detect a start bit while the line is low (break).
REQ-013 Delivery: rx_data, parity_err and frame_err SHALL load together, and rx_valid SHALL rise, on the cycle after completion.
REQ-014 rx_data, parity_err and frame_err SHALL be held stable while rx_valid = 1.
REQ-015 Handshake: rx_valid = 1 and rx_ready = 1 at a rising edge SHALL consume the word; rx_valid SHALL fall next cycle unless a new word loads that same cycle.
REQ-016 Completion and consume in the same cycle SHALL load the new word, and rx_valid SHALL stay 1.
REQ-017 Completion while rx_valid = 1 and rx_ready = 0 SHALL discard the new word, keep the old one, and pulse overrun high for exactly one cycle.
REQ-018 Errored words SHALL still be delivered, with their flags set.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 rst = 1 SHALL immediately set:
- FSM to IDLE, counters to 0, synchronizer flops to 1;
- rx_data to 0;
- rx_valid, parity_err, frame_err, overrun and busy to 0.
REQ-021 rst asserted mid-frame SHALL abandon the partial word with no delivery and no overrun. The first falling edge after release SHALL start a new frame.

Verification
REQ-022 The bench SHALL use CLKS_PER_BIT = 16 and cover these scenarios:
- Defaults (8N1), send 0xE3, rx_ready = 1 -> rx_data = 0xE3, rx_valid high one cycle, about 9.5 bit times after the start edge (+/-3 clocks), no errors.
- PARITY = 2, send 0x5A with parity bit 1 (correct is 0) -> rx_data = 0x5A, parity_err = 1; then send 0x5A with parity bit 0 -> parity_err = 0.
- Send 0x3C with stop bit 0, line held low for 3 bit times -> frame_err = 1, busy = 1 until the line returns high; no spurious frame follows.
- rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; raise rx_ready -> 0x11 consumed, rx_valid falls.
- Low glitch of 4 clocks on idle line -> busy returns to 0, no rx_valid.
- Assert rst at data bit 3 of 0xA5 -> all outputs 0; after release send 0x96 -> rx_data = 0x96, no errors.
- DATA_BITS = 9, STOP_BITS = 2, PARITY = 1, send 0x1A5 -> rx_data = 0x1A5, no errors.
